fifo_unpacker: RTL
==================

# fifo_unpacker

Read-side companion to the common 32-bit FIFOs. Drains length-prefixed packets from a first-word-fall-through 32-bit FIFO (`fifo_32x32` read port) and emits them as a byte stream with valid/ready handshake and end-of-packet marker. Sits between the host-to-target word FIFO and byte-oriented target consumers.

## Interface
- `LEN_BITS`, 16: width of packet length field (header bits [LEN_BITS-1:0]); header bits above are ignored.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  32  FIFO head word, valid whenever `!fifo_empty`.
- `fifo_rden`  out  1  pop FIFO head this cycle; combinational; never asserted while `fifo_empty`.
- `out_valid`  out  1  byte available.
- `out_ready`  in  1  consumer accepts byte.
- `out_data`  out  8  byte value.
- `out_last`  out  1  final byte of packet, qualified by `out_valid`.
- `busy`  out  1  high in any state other than IDLE.
- `err_zero_len`  out  1  one-cycle pulse when a header with length 0 is consumed.

## Operation
- Packet format: one header word, length N (bytes) = header[LEN_BITS-1:0], then ceil(N/4) payload words. Unused bytes of the final word are discarded.
- Byte order: byte 0 = word[7:0], then [15:8], [23:16], [31:24].
- State machine: IDLE, FETCH, SEND.
  - IDLE: if `!fifo_empty`: pop header, load `remaining` = N. N = 0 -> pulse `err_zero_len` next cycle, stay IDLE. N > 0 -> FETCH.
  - FETCH: if `!fifo_empty`: pop word into shift register, byte index = 0, -> SEND. Else wait.
  - SEND: `out_valid` = 1. On accept (`out_valid && out_ready`): `remaining` decrements. If `remaining` was 1 -> IDLE. Else if byte index was 3: if `!fifo_empty`, pop next word in the same cycle and stay in SEND (no bubble). Otherwise -> FETCH. Else index+1.
- `out_last` = (`remaining` == 1) while in SEND.
- `out_valid`, `out_data`, and `out_last` are derived only from registers. There is no combinational path from `out_ready` or `fifo_*`.
- `fifo_rden` is combinational from state, `fifo_empty`, `out_ready`, index, and `remaining`.
- Once `out_valid` is high, `out_data` and `out_last` hold stable until accepted. `out_valid` never drops without an accept.
- `remaining` is LEN_BITS wide and unsigned. Maximum packet is 2^LEN_BITS−1 bytes.
- Reset mid-packet abandons the packet. The FIFO must share the same reset so stale payload is never parsed as a header.

## Timing
- Reset values: state IDLE, `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0, `err_zero_len` 0, `fifo_rden` 0 while reset is asserted. Outputs clear immediately on reset assertion.
- Header pop at cycle t -> earliest payload pop at t+1 -> earliest `out_valid` at t+2.
- Sustained throughput is 1 byte/cycle while `out_ready` = 1 and the FIFO is non-empty at word boundaries.
- Last byte accepted at cycle t -> IDLE at t+1. The next header can be popped at t+1. Inter-packet gap on the output is 2 cycles.
- A pop at a word boundary occurs only in the cycle byte 3 is accepted. A stall on `out_ready` delays the pop.

## Configuration
- `FIFO_UNPACK_MSB_FIRST_EN` defined: bytes are emitted [31:24] first down to [7:0]. Last-word truncation keeps the most significant bytes.
- Undefined (default): LSB-first as above.
- The header length field position is unaffected by this macro.

## Test plan
- N=5, words 0x44332211, 0x000000AA, `out_ready`=1 -> bytes 11,22,33,44,AA with `out_last` only on AA. 3 `fifo_rden` pulses total. First `out_valid` 2 cycles after header pop.
- Header N=0 followed by header N=1 and word 0x000000EF -> `err_zero_len` high exactly 1 cycle, then single byte EF with `out_last`=1.
- N=4, word 0x44332211, `out_ready` toggling 1/0 -> bytes 11,22,33,44 each held stable across stall cycles. No extra pops. Return to IDLE after 44 is accepted.
- N=8, second payload word written 5 cycles late -> `out_valid` low during the gap (FETCH), `busy` high, bytes resume in order with no duplication or loss.
- Reset asserted asynchronously after 2 of 5 bytes accepted -> `out_valid`/`busy`/`fifo_rden` go to 0 without waiting for a clock edge. With FIFO also reset, a new N=2 packet then emits correctly.
- `FIFO_UNPACK_MSB_FIRST_EN` build, N=3, word 0x44332211 -> bytes 44,33,22, `out_last` on 22.

Source files
------------

// File: rtl/fifo_unpacker.sv
// Drains length-prefixed packets from a FWFT 32-bit FIFO and emits them as a byte stream with last marker.
// Optional FIFO_UNPACK_MSB_FIRST_EN emits each word's bytes MSB-first (header length field position unchanged).
module fifo_unpacker #(
  parameter int LEN_BITS = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_dout,
  output logic        o_fifo_rden,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [7:0]  o_out_data,
  output logic        o_out_last,
  output logic        o_busy,
  output logic        o_err_zero_len
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LEN_BITS-1:0] r_remaining;
  logic [31:0]         r_word;
  logic [1:0]          r_idx;
  logic                r_err;

  logic                w_accept;
  logic                w_last_byte;
  logic                w_hdr_zero;
  logic                w_rden;
  logic                w_load_hdr;
  logic                w_load_word;
  logic [1:0]          w_sel;

  assign w_accept    = (r_state == S_SEND) && i_out_ready;
  assign w_last_byte = (r_remaining == LEN_BITS'(1));
  assign w_hdr_zero  = (i_fifo_dout[LEN_BITS-1:0] == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_rden      = 1'b0;
    w_load_hdr  = 1'b0;
    w_load_word = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_fifo_empty) begin
          w_rden     = 1'b1;
          w_load_hdr = 1'b1;
          if (!w_hdr_zero) w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!i_fifo_empty) begin
          w_rden      = 1'b1;
          w_load_word = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_accept) begin
          if (w_last_byte) begin
            w_state_nxt = S_IDLE;
          end else if (r_idx == 2'd3) begin
            // Refill in the same cycle as the byte-3 accept to avoid a bubble.
            if (!i_fifo_empty) begin
              w_rden      = 1'b1;
              w_load_word = 1'b1;
            end else begin
              w_state_nxt = S_FETCH;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_remaining <= '0;
      r_word      <= '0;
      r_idx       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_load_hdr && w_hdr_zero;
      if (w_load_hdr)    r_remaining <= i_fifo_dout[LEN_BITS-1:0];
      else if (w_accept) r_remaining <= r_remaining - LEN_BITS'(1);
      if (w_load_word) begin
        r_word <= i_fifo_dout;
        r_idx  <= 2'd0;
      end else if (w_accept) begin
        r_idx  <= r_idx + 2'd1;
      end
    end
  end

`ifdef FIFO_UNPACK_MSB_FIRST_EN
  assign w_sel = ~r_idx;
`else
  assign w_sel = r_idx;
`endif

  // Reset state is IDLE, so rden must be masked explicitly while reset is held.
  assign o_fifo_rden    = w_rden && !i_reset;
  assign o_out_valid    = (r_state == S_SEND);
  assign o_out_data     = r_word[{w_sel, 3'b000} +: 8];
  assign o_out_last     = (r_state == S_SEND) && w_last_byte;
  assign o_busy         = (r_state != S_IDLE);
  assign o_err_zero_len = r_err;

endmodule
